ad9226_capture_ctrl: RTL and testbench

Capture sequencer for the two AD9226 ADC channels on the GPIO_0 and GPIO_1 headers. It generates the shared ADC sample clock by dividing CLOCK_50 and discards the ADC pipeline latency after each clock start. It latches both 12-bit channels, undoing the bit-reversed wiring of channel 1, and delivers fixed-length bursts of sample pairs over a valid/ready stream to downstream processing.

---
 rtl/ad9226_pkg.sv | 25 ++
 rtl/ad9226_clk_gen.sv | 40 ++++
 rtl/ad9226_capture_ctrl.sv | 159 +++++++++++++++
 tb/tb_ad9226_capture_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9226_pkg.sv
// Shared types for the AD9226 dual-channel capture path: sample word, FSM states
// and the bit-order fix for channel 1, whose data pins are wired MSB-to-LSB.
package ad9226_pkg;

  localparam int SAMPLE_MSB = 11;

  typedef logic [SAMPLE_MSB:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_t;

  function automatic sample_t bitrev(input sample_t s);
    sample_t r;
    for (int i = 0; i <= SAMPLE_MSB; i++) begin
      r[i] = s[SAMPLE_MSB-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ad9226_clk_gen.sv
// ADC clock divider: high for the first half of each period, strobe at the falling edge.
// Counter sits at zero while disabled, so every enable starts a fresh high phase.
module ad9226_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic adc_clk,
  output logic sample_stb,
  output logic period_wrap
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = '0;
    if (en) begin
      div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign adc_clk     = en && (div_q < HALF);
  assign sample_stb  = en && (div_q == HALF);
  assign period_wrap = en && (div_q == LAST);

endmodule

// File: rtl/ad9226_capture_ctrl.sv
// Dual AD9226 burst capture: start -> warm-up of PIPE_LAT ADC periods -> BURST_LEN pairs.
// Single-entry output register, m_valid one cycle after each strobe; a strobe while stalled drops the sample and sets overflow.
module ad9226_capture_ctrl
  import ad9226_pkg::*;
#(
  parameter int AD9226_MSB = 11,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_LAT   = 7,
  parameter int BURST_LEN  = 1024
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET_N,
  input  logic                         start,
  input  logic                         stop,
  output logic                         ADC_CLK_0,
  output logic                         ADC_CLK_1,
  input  logic [AD9226_MSB:0]          ADC_DATA_0,
  input  logic [AD9226_MSB:0]          ADC_DATA_1,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [AD9226_MSB:0]          m_data0,
  output logic [AD9226_MSB:0]          m_data1,
  output logic [$clog2(BURST_LEN)-1:0] m_index,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int WU_W  = $clog2(PIPE_LAT + 1);

  cap_state_t state_q, state_d;
  logic [WU_W-1:0]       wu_q, wu_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  vld_q, vld_d;
  logic [AD9226_MSB:0]   d0_q, d0_d;
  logic [AD9226_MSB:0]   d1_q, d1_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ovf_q, ovf_d;

  logic clk_en;
  logic adc_clk;
  logic sample_stb;
  logic period_wrap;

  assign clk_en = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE);

  ad9226_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk        (CLOCK_50),
    .rst_n      (RESET_N),
    .en         (clk_en),
    .adc_clk    (adc_clk),
    .sample_stb (sample_stb),
    .period_wrap(period_wrap)
  );

  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    if (vld_q && m_ready) begin
      vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_WARMUP;
          wu_d    = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_WARMUP: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (period_wrap) begin
          if (wu_q == WU_W'(PIPE_LAT - 1)) begin
            state_d = ST_CAPTURE;
            wu_d    = '0;
          end else begin
            wu_d = wu_q + 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (sample_stb) begin
          cnt_d = cnt_q + 1'b1;
          // A handshake in this same cycle frees the register for the new sample.
          if (!vld_q || m_ready) begin
            vld_d = 1'b1;
            d0_d  = ADC_DATA_0;
            d1_d  = bitrev(ADC_DATA_1);
            idx_d = cnt_q;
          end else begin
            ovf_d = 1'b1;
          end
          if (cnt_q == IDX_W'(BURST_LEN - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!vld_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      wu_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wu_q    <= wu_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ADC_CLK_0 = adc_clk;
  assign ADC_CLK_1 = adc_clk;
  assign m_valid   = vld_q;
  assign m_data0   = d0_q;
  assign m_data1   = d1_q;
  assign m_index   = idx_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ad9226_capture_ctrl.sv
// Directed bench for ad9226_capture_ctrl with BURST_LEN=8: timing, bit order,
// backpressure, abort, start/stop collisions and mid-burst reset.
module tb_ad9226_capture_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        start;
  logic        stop;
  logic        ADC_CLK_0;
  logic        ADC_CLK_1;
  logic [11:0] ADC_DATA_0;
  logic [11:0] ADC_DATA_1;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_data0;
  logic [11:0] m_data1;
  logic [2:0]  m_index;
  logic        busy;
  logic        done;
  logic        overflow;

  ad9226_capture_ctrl #(
    .AD9226_MSB(11),
    .CLK_DIV   (4),
    .PIPE_LAT  (7),
    .BURST_LEN (8)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .start     (start),
    .stop      (stop),
    .ADC_CLK_0 (ADC_CLK_0),
    .ADC_CLK_1 (ADC_CLK_1),
    .ADC_DATA_0(ADC_DATA_0),
    .ADC_DATA_1(ADC_DATA_1),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data0   (m_data0),
    .m_data1   (m_data1),
    .m_index   (m_index),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_assert = 0;
  int n_fail   = 0;

  // Cycle count relative to the start pulse (cycle 0 = start driven).
  int cyc      = 0;
  int start_at = -100;
  int stop_at  = -100;
  int stall_lo = -1;
  int stall_hi = -2;
  bit ramp_mode = 1'b1;

  int n_hs;
  int hs_idx [16];
  int hs_cyc [16];
  int hs_d0  [16];
  int hs_d1  [16];
  int first_vld;
  int done_cnt;
  int done_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [11:0] r;
    if (m_valid === 1'b1 && m_ready === 1'b1 && n_hs < 16) begin
      hs_idx[n_hs] = int'(m_index);
      hs_cyc[n_hs] = cyc;
      hs_d0[n_hs]  = int'(m_data0);
      hs_d1[n_hs]  = int'(m_data1);
      n_hs++;
    end
    if (m_valid === 1'b1 && first_vld < 0) first_vld = cyc;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge CLOCK_50);
    #1;
    cyc++;
    start   = (cyc == start_at);
    stop    = (cyc == stop_at);
    m_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    if (ramp_mode) begin
      // Sample k is latched at cycle 31+4k; the ramp value equals k there.
      r = (cyc >= 29) ? 12'((cyc - 29) / 4) : 12'hFFF;
      ADC_DATA_0 = r;
      ADC_DATA_1 = {<<{r}};
    end else if (cyc < 33) begin
      ADC_DATA_0 = 12'h5A3;
      ADC_DATA_1 = 12'h001;
    end else begin
      ADC_DATA_0 = 12'hC3C;
      ADC_DATA_1 = 12'hA50;
    end
  endtask

  task automatic begin_burst();
    n_hs      = 0;
    first_vld = -1;
    done_cnt  = 0;
    done_cyc  = -1;
    cyc       = 0;
    start     = 1'b1;
    tick();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_busy_after_done"}, busy, 0);
    repeat (4) tick();
  endtask

  initial begin
    RESET_N    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    m_ready    = 1'b1;
    ADC_DATA_0 = 12'h000;
    ADC_DATA_1 = 12'h000;
    n_hs = 0; first_vld = -1; done_cnt = 0; done_cyc = -1;
    repeat (3) tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_data0", m_data0, 0);
    chk("rst_data1", m_data1, 0);
    chk("rst_index", m_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_clk", {ADC_CLK_1, ADC_CLK_0}, 0);
    RESET_N = 1'b1;
    repeat (2) tick();

    // Nominal burst
    begin_burst();
    chk("nom_busy_t1", busy, 1);
    chk("nom_clk_t1", {ADC_CLK_1, ADC_CLK_0}, 2'b11);
    run_to_done("nom");
    chk("nom_first_vld", first_vld, 32);
    chk("nom_count", n_hs, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("nom_idx%0d", k), hs_idx[k], k);
      chk($sformatf("nom_cyc%0d", k), hs_cyc[k], 32 + 4 * k);
      chk($sformatf("nom_d0_%0d", k), hs_d0[k], k);
      chk($sformatf("nom_d1_%0d", k), hs_d1[k], k);
    end
    chk("nom_done_cyc", done_cyc, 62);
    chk("nom_done_once", done_cnt, 1);
    chk("nom_ovf", overflow, 0);

    // Bit reversal with fixed vectors
    ramp_mode = 1'b0;
    begin_burst();
    run_to_done("rev");
    chk("rev_d0_a", hs_d0[0], 32'h5A3);
    chk("rev_d1_a", hs_d1[0], 32'h800);
    chk("rev_d0_b", hs_d0[1], 32'hC3C);
    chk("rev_d1_b", hs_d1[1], 32'h0A5);
    ramp_mode = 1'b1;

    // Backpressure: m_ready low for 6 cycles from the first m_valid
    stall_lo = 32; stall_hi = 37;
    begin_burst();
    run_to_done("bp");
    chk("bp_count", n_hs, 7);
    chk("bp_first_cyc", hs_cyc[0], 38);
    chk("bp_idx0", hs_idx[0], 0);
    chk("bp_idx_skip", hs_idx[1], 2);
    chk("bp_d0_skip", hs_d0[1], 2);
    chk("bp_idx_last", hs_idx[6], 7);
    chk("bp_ovf", overflow, 1);
    chk("bp_done_cyc", done_cyc, 62);

    // Abort after 3 samples with the third still pending
    stall_lo = 40; stall_hi = 44;
    stop_at  = 41;
    begin_burst();
    chk("ovf_cleared_by_start", overflow, 0);
    run_to(41);
    chk("abort_clk_before", ADC_CLK_0, 1);
    run_to(42);
    chk("abort_clk_low", {ADC_CLK_1, ADC_CLK_0}, 0);
    chk("abort_busy", busy, 1);
    chk("abort_pending", m_valid, 1);
    run_to_done("abort");
    chk("abort_count", n_hs, 3);
    chk("abort_idx2", hs_idx[2], 2);
    chk("abort_drain_cyc", hs_cyc[2], 45);
    chk("abort_done_cyc", done_cyc, 47);
    chk("abort_done_once", done_cnt, 1);
    stall_lo = -1; stall_hi = -2; stop_at = -100;

    // start during CAPTURE is ignored
    start_at = 45;
    begin_burst();
    run_to_done("startcap");
    chk("startcap_count", n_hs, 8);
    chk("startcap_done_cyc", done_cyc, 62);
    start_at = -100;

    // start+stop together in IDLE
    start_at = cyc + 1;
    stop_at  = cyc + 1;
    tick();
    tick();
    chk("ss_idle_busy", busy, 0);
    tick();
    chk("ss_idle_busy2", busy, 0);
    start_at = -100; stop_at = -100;

    // Reset during WARMUP
    begin_burst();
    run_to(10);
    chk("rw_busy_pre", busy, 1);
    RESET_N = 1'b0;
    tick();
    chk("rw_busy", busy, 0);
    chk("rw_clk", {ADC_CLK_1, ADC_CLK_0}, 0);
    chk("rw_done", done, 0);
    RESET_N = 1'b1;
    tick();

    // Reset during CAPTURE with a pending sample and overflow set
    ramp_mode = 1'b0;
    stall_lo = 32; stall_hi = 40;
    begin_burst();
    run_to(37);
    chk("rc_ovf_pre", overflow, 1);
    chk("rc_vld_pre", m_valid, 1);
    chk("rc_d0_pre", m_data0, 12'h5A3);
    RESET_N = 1'b0;
    tick();
    chk("rc_valid", m_valid, 0);
    chk("rc_data0", m_data0, 0);
    chk("rc_data1", m_data1, 0);
    chk("rc_index", m_index, 0);
    chk("rc_ovf", overflow, 0);
    chk("rc_busy", busy, 0);
    chk("rc_done", done, 0);
    chk("rc_clk", {ADC_CLK_1, ADC_CLK_0}, 0);
    RESET_N = 1'b1;
    stall_lo = -1; stall_hi = -2;
    ramp_mode = 1'b1;
    tick();

    // Fresh burst after reset behaves nominally
    begin_burst();
    run_to_done("post");
    chk("post_first_vld", first_vld, 32);
    chk("post_count", n_hs, 8);
    chk("post_idx7", hs_idx[7], 7);
    chk("post_d0_5", hs_d0[5], 5);
    chk("post_done_cyc", done_cyc, 62);
    chk("post_ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
